// File: rtl/conv_mac_if.sv
// Device-bus port bundle for the convolution MAC engine: a held request
// from the master, answered by a one-cycle ready pulse carrying read data.
interface conv_mac_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            en;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            ready;
  logic [XLEN-1:0] rdata;

  modport master (output en, we, addr, wdata, input ready, rdata);
  modport slave  (input en, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/conv_mac_engine.sv
// Memory-mapped FP32 convolution MAC: weight buffer plus a chained FMA that accumulates one window.
// Build option RELU_EN clamps negative results to +0 on the result read and sets status bit 15.
module conv_mac_engine #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned KSIZE     = 25,
  parameter logic [31:0] BASE_ADDR = 32'hC430_0000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  conv_mac_if.slave  bus
);
  localparam int unsigned PW      = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int unsigned FMA_LAT = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic [2:0] {
    R_WEIGHT = 3'd0, R_ACT = 3'd1, R_BIAS = 3'd2, R_RESULT = 3'd3,
    R_STATUS = 3'd4, R_CTRL = 3'd5, R_NONE = 3'd7
  } reg_e;

  // Single-rounding FP32 a*b+c; denormals flush to zero, inf/NaN inputs are not special-cased.
  function automatic logic [74:0] shr_sticky(input logic [74:0] v, input logic [11:0] sh);
    logic [74:0] mask;
    if (sh >= 12'd75) return {74'h0, |v};
    mask = ~({75{1'b1}} << sh);
    return (v >> sh) | {74'h0, |(v & mask)};
  endfunction

  function automatic logic [31:0] fma32(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    logic               sp, sc, sr, grd, stk;
    logic [47:0]        p;
    logic signed [11:0] ep, ec, er;
    logic [74:0]        x, y, m, n;
    logic [6:0]         l;
    logic [24:0]        mr;
    sp = a[31] ^ b[31];
    sc = c[31];
    p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    ep = $signed({4'b0, a[30:23]}) + $signed({4'b0, b[30:23]}) - 12'sd127;
    ec = $signed({4'b0, c[30:23]});
    x  = {1'b0, p, 26'b0};
    y  = {2'b00, 1'b1, c[22:0], 49'b0};
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin x = '0; ep = ec; end
    if (c[30:23] == 8'd0) begin y = '0; ec = ep; end
    if (ep >= ec) begin er = ep; y = shr_sticky(y, $unsigned(ep - ec)); end
    else          begin er = ec; x = shr_sticky(x, $unsigned(ec - ep)); end
    if (sp == sc)    begin m = x + y; sr = sp; end
    else if (x >= y) begin m = x - y; sr = sp; end
    else             begin m = y - x; sr = sc; end
    if (m == '0) return 32'h0;
    l = '0;
    for (int i = 0; i < 75; i++) if (m[i]) l = 7'(i);
    n   = m << (7'd74 - l);
    grd = n[50];
    stk = |n[49:0];
    mr  = {1'b0, n[74:51]} + 25'(grd & (stk | n[51]));
    er  = er - 12'sd72 + $signed({5'b0, l});
    if (mr[24]) er = er + 12'sd1;
    if (er <= 12'sd0)   return {sr, 31'h0};
    if (er >= 12'sd255) return {sr, 8'hFF, 23'h0};
    return {sr, er[7:0], mr[24] ? 23'h0 : mr[22:0]};
  endfunction

  state_e          state_q, state_d;
  reg_e            sel;
  logic            capture, fma_vld, done_q, ovf_q;
  logic [PW-1:0]   wptr_q, tap_q;
  logic [XLEN-1:0] acc_q, bias_q, result_q, act_q, rd_q, rd_val, status, result_rd, fma_c, fma_res;
  logic [31:0]     off;
  logic [XLEN-1:0] weight_mem [KSIZE];
  logic [XLEN-1:0] fma_pipe   [FMA_LAT];
  logic [FMA_LAT-1:0] vld_pipe;

`ifdef RELU_EN
  localparam logic RELU_BIT = 1'b1;
  assign result_rd = result_q[31] ? '0 : result_q;
`else
  localparam logic RELU_BIT = 1'b0;
  assign result_rd = result_q;
`endif

  assign off     = bus.addr - BASE_ADDR;
  assign status  = {ovf_q, done_q, (state_q != S_IDLE), 13'(tap_q), RELU_BIT, 2'b00, 13'(wptr_q)};
  assign fma_c   = (tap_q == '0) ? bias_q : acc_q;
  assign fma_vld = vld_pipe[FMA_LAT-1];
  assign fma_res = fma_pipe[FMA_LAT-1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel = R_NONE;
    if (off[31:5] == '0 && off[1:0] == 2'b00 && off[4:2] <= 3'd5) sel = reg_e'(off[4:2]);
    rd_val = '0;
    if (!bus.we) begin
      case (sel)
        R_RESULT: rd_val = result_rd;
        R_STATUS: rd_val = status;
        default:  rd_val = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.en && !bus.ready) begin
        capture = 1'b1;
        state_d = (bus.we && sel == R_ACT) ? S_ISSUE : S_RESP;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (fma_vld) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      bus.ready <= 1'b0;
      bus.rdata <= '0;
      wptr_q    <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      bias_q    <= '0;
      result_q  <= '0;
      act_q     <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus.ready <= (state_q == S_RESP);
      if (state_q == S_RESP) bus.rdata <= rd_q;
      // Side effects and read data are taken at capture, while the engine is still idle.
      if (capture) begin
        rd_q  <= rd_val;
        act_q <= bus.wdata;
        if (bus.we) begin
          case (sel)
            R_WEIGHT: wptr_q <= (wptr_q == PW'(KSIZE - 1)) ? '0 : wptr_q + PW'(1);
            R_BIAS:   bias_q <= bus.wdata;
            R_CTRL:   if (bus.wdata[0]) begin
              wptr_q <= '0;
              tap_q  <= '0;
              acc_q  <= '0;
              done_q <= 1'b0;
              ovf_q  <= 1'b0;
            end
            default: ;
          endcase
        end else if (sel == R_RESULT) begin
          done_q <= 1'b0;
          ovf_q  <= 1'b0;
        end
      end
      if (state_q == S_WAIT && fma_vld) begin
        acc_q <= fma_res;
        if (tap_q == PW'(KSIZE - 1)) begin
          result_q <= fma_res;
          ovf_q    <= done_q;
          done_q   <= 1'b1;
          tap_q    <= '0;
        end else begin
          tap_q <= tap_q + PW'(1);
        end
      end
    end
  end

  // NOTE: the weight RAM and FMA data stages carry no reset so they map to plain storage;
  // weights deliberately survive reset, and only the valid chain needs clearing.
  always_ff @(posedge clk_i) begin
    if (capture && bus.we && sel == R_WEIGHT) weight_mem[wptr_q] <= bus.wdata;
    if (state_q == S_ISSUE) fma_pipe[0] <= fma32(weight_mem[tap_q], act_q, fma_c);
    for (int i = 1; i < FMA_LAT; i++) fma_pipe[i] <= fma_pipe[i-1];
  end

  // Clearing the valid chain on reset discards any result still in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[FMA_LAT-2:0], (state_q == S_ISSUE)};
  end
endmodule
